// File: rtl/imm_instr_encoder_if.sv
// Stream interface for the immediate instruction encoder.
// Carries the input offer (base word, immediate, format code) and the
// encoded output word with its address and error flag.
interface imm_instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_base;
    logic [31:0]       in_imm;
    logic [2:0]        in_imm_src;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    // Producer of input words and consumer of encoded words
    modport master (
        output in_valid, in_base, in_imm, in_imm_src, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    // The encoder's own view
    modport slave (
        input  in_valid, in_base, in_imm, in_imm_src, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/imm_instr_encoder.sv
// Immediate instruction encoder: scatters an immediate into the I/S/B/J/U
// field positions of a base instruction, checks range/alignment, and issues
// the result through a one-deep output register with an auto-incrementing
// word address.
// Optional build macro IMM_ROUNDTRIP_CHECK_EN: re-decodes every encoded word
// and flags an error when the decoded immediate differs from the input.
module imm_instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    imm_instr_encoder_if.slave bus,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_load_val,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       instr_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] addr_cnt_reg;
    logic              err_sticky_reg;
    logic [ADDR_W:0]   word_count_reg;

    logic [31:0]       instr_next;
    logic              err_next;
    logic              range_err;
    logic              accept;
    logic              xfer;
    logic [ADDR_W-1:0] word_addr;

    assign bus.in_ready  = (state_reg == EMPTY) || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign xfer          = (state_reg == FULL) && bus.out_ready;
    assign word_addr     = addr_load ? addr_load_val : addr_cnt_reg;

    assign bus.out_valid = (state_reg == FULL);
    assign bus.out_instr = instr_reg;
    assign bus.out_addr  = out_addr_reg;
    assign bus.out_err   = err_reg;
    assign err_sticky    = err_sticky_reg;
    assign word_count    = word_count_reg;

    // Scatter immediate bits into the format's field positions and range-check
    always_comb begin
        instr_next = bus.in_base;
        range_err  = 1'b0;
        unique case (bus.in_imm_src)
            SRC_I: begin
                instr_next[31:20] = bus.in_imm[11:0];
                range_err = !((bus.in_imm[31:11] == '0) || (bus.in_imm[31:11] == '1));
            end
            SRC_S: begin
                instr_next[31:25] = bus.in_imm[11:5];
                instr_next[11:7]  = bus.in_imm[4:0];
                range_err = !((bus.in_imm[31:11] == '0) || (bus.in_imm[31:11] == '1));
            end
            SRC_B: begin
                instr_next[31]    = bus.in_imm[12];
                instr_next[7]     = bus.in_imm[11];
                instr_next[30:25] = bus.in_imm[10:5];
                instr_next[11:8]  = bus.in_imm[4:1];
                range_err = !((bus.in_imm[31:12] == '0) || (bus.in_imm[31:12] == '1))
                            || bus.in_imm[0];
            end
            SRC_J: begin
                instr_next[31]    = bus.in_imm[20];
                instr_next[19:12] = bus.in_imm[19:12];
                instr_next[20]    = bus.in_imm[11];
                instr_next[30:21] = bus.in_imm[10:1];
                range_err = !((bus.in_imm[31:20] == '0) || (bus.in_imm[31:20] == '1))
                            || bus.in_imm[0];
            end
            SRC_U: begin
                instr_next[31:12] = bus.in_imm[31:12];
                range_err = (bus.in_imm[11:0] != 12'h000);
            end
            default: begin
                range_err = 1'b1;
            end
        endcase
    end

`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic [31:0] dec_imm;

    // Re-decode the encoded word with the standard extension rules
    always_comb begin
        dec_imm = bus.in_imm;
        unique case (bus.in_imm_src)
            SRC_I:   dec_imm = {{20{instr_next[31]}}, instr_next[31:20]};
            SRC_S:   dec_imm = {{20{instr_next[31]}}, instr_next[31:25], instr_next[11:7]};
            SRC_B:   dec_imm = {{19{instr_next[31]}}, instr_next[31], instr_next[7],
                                instr_next[30:25], instr_next[11:8], 1'b0};
            SRC_J:   dec_imm = {{11{instr_next[31]}}, instr_next[31], instr_next[19:12],
                                instr_next[20], instr_next[30:21], 1'b0};
            SRC_U:   dec_imm = {instr_next[31:12], 12'h000};
            default: dec_imm = bus.in_imm;
        endcase
    end

    assign err_next = range_err || (dec_imm != bus.in_imm);
`else
    assign err_next = range_err;
`endif

    // Output stage next-state: EMPTY/FULL occupancy
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (bus.out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // State register and output word capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            instr_reg    <= '0;
            out_addr_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                instr_reg    <= instr_next;
                out_addr_reg <= word_addr;
                err_reg      <= err_next;
            end
        end
    end

    // Address counter: load takes priority, advances once per accepted word
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_reg <= '0;
        end else if (accept) begin
            addr_cnt_reg <= word_addr + ADDR_ONE;
        end else if (addr_load) begin
            addr_cnt_reg <= addr_load_val;
        end
    end

    // Sticky error (set beats clear) and saturating transfer counter
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_reg <= 1'b0;
            word_count_reg <= '0;
        end else begin
            if (accept && err_next) begin
                err_sticky_reg <= 1'b1;
            end else if (err_clr) begin
                err_sticky_reg <= 1'b0;
            end
            if (xfer && (word_count_reg != '1)) begin
                word_count_reg <= word_count_reg + CNT_ONE;
            end
        end
    end
endmodule
